// File: rtl/rx_queue.sv
// Receive queue: 4-phase send/ack capture into a DEPTH-entry FIFO with a valid/ready drain.
// Define RXQ_ERR_CHECK_EN to add the sticky upstream protocol checker and its rxq_err port.
module rx_queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     rxq_clock,
  input  logic                     rxq_reset,
  input  logic                     rxq_send,
  input  logic [WIDTH-1:0]         rxq_in_dados,
  output logic                     rxq_ack,
  output logic [WIDTH-1:0]         rxq_out_dados,
  output logic                     rxq_out_valid,
  input  logic                     rxq_out_ready,
  output logic [$clog2(DEPTH):0]   rxq_count,
  output logic                     rxq_full,
  output logic                     rxq_empty
`ifdef RXQ_ERR_CHECK_EN
  ,
  output logic                     rxq_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Full/empty come from the registered count, so a pop never frees a slot for a same-cycle push.
  assign rxq_full      = (r_count == CW'(DEPTH));
  assign rxq_empty     = (r_count == '0);
  assign rxq_out_valid = ~rxq_empty;
  assign rxq_out_dados = r_mem[r_head];
  assign rxq_count     = r_count;
  assign rxq_ack       = (r_state == ACK);
  assign w_pop         = rxq_out_valid & rxq_out_ready;

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      IDLE: begin
        if (rxq_send && !rxq_full) begin
          w_push       = 1'b1;
          w_state_next = ACK;
        end
      end
      ACK: begin
        if (!rxq_send) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge rxq_clock or negedge rxq_reset) begin
    if (!rxq_reset) begin
      r_state <= IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge rxq_clock) begin
    if (w_push) r_mem[r_tail] <= rxq_in_dados;
  end

`ifdef RXQ_ERR_CHECK_EN
  logic             r_stall;
  logic [WIDTH-1:0] r_stall_dados;
  logic             r_err;

  // A stalled sender must hold its word steady and keep rxq_send high until captured.
  always_ff @(posedge rxq_clock or negedge rxq_reset) begin
    if (!rxq_reset) begin
      r_stall       <= 1'b0;
      r_stall_dados <= '0;
      r_err         <= 1'b0;
    end else begin
      r_stall       <= (r_state == IDLE) && rxq_send && rxq_full;
      r_stall_dados <= rxq_in_dados;
      if (r_stall && (r_state == IDLE) && (!rxq_send || (rxq_in_dados != r_stall_dados)))
        r_err <= 1'b1;
    end
  end

  assign rxq_err = r_err;
`endif

endmodule

// File: tb/tb_rx_queue.sv
// Scoreboard bench for rx_queue: directed handshakes push expectations, a negedge monitor checks pops.
module tb_rx_queue;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             send = 1'b0;
  logic             ready = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             ack;
  logic             valid;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] dout;
  logic [2:0]       count;
`ifdef RXQ_ERR_CHECK_EN
  logic             err;
`endif

  int total = 0;
  int bad = 0;
  logic [WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  rx_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .rxq_clock     (clk),
    .rxq_reset     (rst_n),
    .rxq_send      (send),
    .rxq_in_dados  (din),
    .rxq_ack       (ack),
    .rxq_out_dados (dout),
    .rxq_out_valid (valid),
    .rxq_out_ready (ready),
    .rxq_count     (count),
    .rxq_full      (full),
    .rxq_empty     (empty)
`ifdef RXQ_ERR_CHECK_EN
    ,
    .rxq_err       (err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise send with a word and return once ack is high (bounded).
  task automatic send_start(input logic [WIDTH-1:0] d);
    int n;
    exp_q.push_back(d);
    send = 1'b1;
    din  = d;
    n    = 0;
    tick();
    while (!ack && n < 20) begin
      tick();
      n++;
    end
    check("ack_rise", ack, 1);
    $display("send data=%h count=%0d", d, count);
  endtask

  task automatic send_end();
    send = 1'b0;
    tick();
    check("ack_fall", ack, 0);
  endtask

  task automatic drain();
    int n;
    ready = 1'b1;
    n = 0;
    while (!empty && n < 20) begin
      tick();
      n++;
    end
    ready = 1'b0;
    check("drain_empty", empty, 1);
  endtask

  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %0h expected none", dout);
      end else begin
        e = exp_q.pop_front();
        check("pop_data", dout, e);
        $display("pop data=%h expected=%h", dout, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", valid, 0);
    check("rst_ack", ack, 0);
`ifdef RXQ_ERR_CHECK_EN
    check("rst_err", err, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Single word, consumer stalled
    send_start(4'h3);
    check("single_count", count, 1);
    check("single_dout", dout, 4'h3);
    check("single_valid", valid, 1);
    send_end();
    drain();

    // Fill to full, fifth word backpressured until one pop
    send_start(4'h1); send_end();
    send_start(4'h2); send_end();
    send_start(4'h3); send_end();
    send_start(4'h4); send_end();
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    exp_q.push_back(4'h5);
    send = 1'b1;
    din  = 4'h5;
    repeat (3) begin
      tick();
      check("stall_ack", ack, 0);
    end
    check("stall_count", count, 4);
`ifdef RXQ_ERR_CHECK_EN
    check("stall_err_clean", err, 0);
`endif
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("pop_no_push_ack", ack, 0);
    check("pop_no_push_count", count, 3);
    check("pop_no_push_full", full, 0);
    tick();
    check("late_capture_ack", ack, 1);
    check("late_capture_count", count, 4);
    send_end();
    drain();

    // Streaming 0..15 with consumer always ready
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_start(4'(i));
      check("stream_count_hi", count, 1);
      send_end();
      check("stream_count_lo", count, 0);
    end
    ready = 1'b0;
    check("stream_empty", empty, 1);

    // Simultaneous push and pop at count 2
    send_start(4'hA); send_end();
    send_start(4'hB); send_end();
    check("pp_pre_count", count, 2);
    exp_q.push_back(4'hC);
    send  = 1'b1;
    din   = 4'hC;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("pp_count", count, 2);
    check("pp_ack", ack, 1);
    send_end();
    drain();

    // Asynchronous reset mid-handshake with count 3
    send_start(4'h1); send_end();
    send_start(4'h2); send_end();
    send_start(4'h3);
    check("arst_pre_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ack", ack, 0);
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_valid", valid, 0);
    check("arst_full", full, 0);
    exp_q.delete();

    // Send already high when reset releases is captured at the first edge
    din = 4'h9;
    exp_q.push_back(4'h9);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_ack", ack, 1);
    check("rel_count", count, 1);
    check("rel_dout", dout, 4'h9);
    send_end();
    drain();

    // Data changes while stalled on a full queue
    send_start(4'h4); send_end();
    send_start(4'h5); send_end();
    send_start(4'h6); send_end();
    send_start(4'h7); send_end();
    check("err_fill_full", full, 1);
    send = 1'b1;
    din  = 4'hA;
    tick();
    check("err_stall_ack", ack, 0);
    din = 4'hB;
    tick();
    check("err_stall_count", count, 4);
`ifdef RXQ_ERR_CHECK_EN
    check("err_set", err, 1);
`endif
    send = 1'b0;
    repeat (3) tick();
`ifdef RXQ_ERR_CHECK_EN
    check("err_sticky", err, 1);
`endif
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("err_rst_empty", empty, 1);
`ifdef RXQ_ERR_CHECK_EN
    check("err_rst_clear", err, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
